// File: rtl/toggle_pulse_gen_if.sv
// Button-conditioning bus: raw button level in, clean toggle pulse,
// debounced level and pulse counter out.
interface toggle_pulse_gen_if;
    logic       btn_in;
    logic       t_pulse;
    logic       btn_stable;
    logic [7:0] pulse_count;

    modport master (
        output btn_in,
        input  t_pulse,
        input  btn_stable,
        input  pulse_count
    );

    modport slave (
        input  btn_in,
        output t_pulse,
        output btn_stable,
        output pulse_count
    );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Synchronizes and debounces a raw push-button, then emits a one-cycle
// t_pulse per press with optional auto-repeat while the button is held.
module toggle_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic              clk,
    input  logic              reset,
    toggle_pulse_gen_if.slave bus
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          pulse_q, pulse_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [7:0]    count_q, count_d;
    state_t        state_q, state_d;
    logic          rise, fall;

    always_comb begin
        sync1_d  = bus.btn_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        rise     = 1'b0;
        fall     = 1'b0;

        if (sync2_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            dcnt_d   = '0;
            rise     = sync2_q;
            fall     = ~sync2_q;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end

        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;

        // A release wins over any repeat pulse falling due on the same edge.
        if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (REPEAT_EN != 0) begin
                        if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
                            state_d = REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        count_d = pulse_d ? count_q + 8'd1 : count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            dcnt_q   <= '0;
            rcnt_q   <= '0;
            count_q  <= 8'd0;
            state_q  <= IDLE;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            dcnt_q   <= dcnt_d;
            rcnt_q   <= rcnt_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    assign bus.t_pulse     = pulse_q;
    assign bus.btn_stable  = stable_q;
    assign bus.pulse_count = count_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed and randomized checks of toggle_pulse_gen (repeat on and off)
// against a sliding-window / elapsed-time reference model.
module tb_toggle_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 16;
    localparam int RP = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    toggle_pulse_gen_if bif_a ();
    toggle_pulse_gen_if bif_b ();

    toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        dut_a (.clk(clk), .reset(reset), .bus(bif_a.slave));
    toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        dut_b (.clk(clk), .reset(reset), .bus(bif_b.slave));

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state: recent btn_in samples, debounced level,
    // edge at which the current press was accepted, expected outputs.
    bit         hist[$];
    bit         m_stable;
    int         press_edge;
    bit         m_pulse[2];
    logic [7:0] m_count[2];

    int  edge_n = 0;
    int  e0     = 0;
    int  plog[$];
    int  fall_rel;
    bit  prev_stable;
    bit  stable_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int log_at(input int i);
        return (plog.size() > i) ? plog[i] : -1;
    endfunction

    task automatic set_btn(input bit b);
        bif_a.btn_in = b;
        bif_b.btn_in = b;
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (D + 2) hist.push_back(1'b0);
        m_stable   = 1'b0;
        press_edge = 0;
        m_pulse[0] = 1'b0;
        m_pulse[1] = 1'b0;
        m_count[0] = 8'd0;
        m_count[1] = 8'd0;
    endtask

    // btn_stable flips when the samples taken 2..D+1 edges ago all disagree with it;
    // pulses occur at press acceptance and then at RD, RD+RP, RD+2RP... edges later.
    task automatic model_edge(input bit s);
        bit all_diff, rise, fall, p;
        int held;
        hist.push_back(s);
        if (hist.size() > D + 2) void'(hist.pop_front());
        all_diff = 1'b1;
        for (int i = 0; i < D; i++)
            if (hist[hist.size() - 3 - i] == m_stable) all_diff = 1'b0;
        rise = all_diff && !m_stable;
        fall = all_diff && m_stable;
        if (all_diff) m_stable = ~m_stable;
        if (rise) press_edge = edge_n;
        for (int k = 0; k < 2; k++) begin
            p = 1'b0;
            if (rise) begin
                p = 1'b1;
            end else if (m_stable && !fall) begin
                held = edge_n - press_edge;
                if (k == 0 && held >= RD && ((held - RD) % RP) == 0) p = 1'b1;
            end
            m_pulse[k] = p;
            if (p) m_count[k] = m_count[k] + 8'd1;
        end
    endtask

    task automatic step(input bit b);
        set_btn(b);
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(b);
        check("t_pulse_a",     bif_a.t_pulse,     m_pulse[0]);
        check("btn_stable_a",  bif_a.btn_stable,  m_stable);
        check("pulse_count_a", bif_a.pulse_count, m_count[0]);
        check("t_pulse_b",     bif_b.t_pulse,     m_pulse[1]);
        check("btn_stable_b",  bif_b.btn_stable,  m_stable);
        check("pulse_count_b", bif_b.pulse_count, m_count[1]);
        if (bif_a.t_pulse) plog.push_back(edge_n - e0);
        if (bif_a.btn_stable) stable_seen = 1'b1;
        if (prev_stable && !bif_a.btn_stable) fall_rel = edge_n - e0;
        prev_stable = bif_a.btn_stable;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_t_pulse"},     bif_a.t_pulse,     0);
        check({tag, "_btn_stable"},  bif_a.btn_stable,  0);
        check({tag, "_pulse_count"}, bif_a.pulse_count, 0);
        check({tag, "_pulse_count_b"}, bif_b.pulse_count, 0);
    endtask

    task automatic reset_step(input bit b);
        set_btn(b);
        @(posedge clk);
        #1;
        edge_n++;
        prev_stable = 1'b0;
        check_zero("in_reset");
    endtask

    task automatic do_reset(input bit b);
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        reset_step(b);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic new_test();
        e0 = edge_n + 1;
        plog.delete();
        fall_rel    = -1;
        stable_seen = 1'b0;
    endtask

    initial begin
        set_btn(1'b1);
        model_reset();
        prev_stable = 1'b0;
        #1;
        check_zero("reset_start");
        reset_step(1'b1);
        reset_step(1'b1);
        @(negedge clk);
        reset = 1'b1;

        // Button already held when reset releases
        new_test();
        repeat (8) step(1'b1);
        check("t1_first_pulse_edge", log_at(0), 5);
        repeat (12) step(1'b0);

        // Clean press
        do_reset(1'b0);
        new_test();
        repeat (10) step(1'b1);
        repeat (12) step(1'b0);
        check("t2_pulses", plog.size(), 1);
        check("t2_pulse_edge", log_at(0), 5);
        check("t2_fall_edge", fall_rel, 15);
        check("t2_count", bif_a.pulse_count, 1);

        // Bounce never long enough to debounce
        do_reset(1'b0);
        new_test();
        step(1'b1); step(1'b1); step(1'b0); step(1'b1);
        step(1'b1); step(1'b0); step(1'b1);
        repeat (10) step(1'b0);
        check("t3_pulses", plog.size(), 0);
        check("t3_stable_seen", stable_seen, 0);
        check("t3_count", bif_a.pulse_count, 0);

        // Long hold with auto-repeat; release coincides with a due repeat
        do_reset(1'b0);
        new_test();
        repeat (40) step(1'b1);
        repeat (12) step(1'b0);
        check("t4_pulses", plog.size(), 4);
        check("t4_pulse0", log_at(0), 5);
        check("t4_pulse1", log_at(1), 21);
        check("t4_pulse2", log_at(2), 29);
        check("t4_pulse3", log_at(3), 37);
        check("t4_fall_edge", fall_rel, 45);
        check("t4_count_repeat", bif_a.pulse_count, 4);
        check("t4_count_norepeat", bif_b.pulse_count, 1);

        // Random bouncy activity against the model
        new_test();
        for (int r = 0; r < 150; r++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 30));
            repeat (len) step(v);
        end
        repeat (12) step(1'b0);

        // 256 clean presses wrap the counter
        do_reset(1'b0);
        new_test();
        for (int p = 0; p < 256; p++) begin
            repeat (int'($urandom_range(5, 15))) step(1'b1);
            repeat (int'($urandom_range(6, 12))) step(1'b0);
        end
        check("t5_pulses", plog.size(), 256);
        check("t5_count_wrap_a", bif_a.pulse_count, 0);
        check("t5_count_wrap_b", bif_b.pulse_count, 0);

        // Reset mid-repeat with the button still held
        do_reset(1'b0);
        new_test();
        repeat (25) step(1'b1);
        check("t6_count_before", bif_a.pulse_count, 2);
        do_reset(1'b1);
        new_test();
        repeat (8) step(1'b1);
        check("t6_first_pulse_edge", log_at(0), 1 + D);
        check("t6_count_after", bif_a.pulse_count, 1);
        repeat (12) step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
Upstream conditioning stage for the t_flipflop block. It takes a raw, bouncy, asynchronous push-button level and produces a clean one-cycle t_pulse that drives the flip-flop's T input, so each press toggles Q exactly once. Holding the button produces auto-repeat pulses. A wrapping press/pulse counter is provided for bench and debug visibility.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clocks the synchronized input must differ from btn_stable before btn_stable updates (>=2)
REPEAT_EN, 1, 1 = auto-repeat while held; 0 = single pulse per press
REPEAT_DELAY, 16, clocks from the initial pulse to the first repeat pulse (>=2)
REPEAT_PERIOD, 8, clocks between successive repeat pulses (>=2)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
btn_in  input  1  raw asynchronous button level, 1 = pressed
t_pulse  output  1  registered one-cycle pulse; connects to t_flipflop T
btn_stable  output  1  registered debounced button level
pulse_count  output  8  number of t_pulse assertions, modulo 256

Behaviour:
- Reset (reset=0, asynchronous): sync1, sync2, btn_stable, t_pulse, debounce counter, repeat counter and pulse_count all go to 0; FSM goes to IDLE. Release is sampled on the next rising clk edge.
- Synchronizer: two flops, btn_in -> sync1 -> sync2. No logic sits between them.
- Debounce, evaluated every edge using pre-edge values:
  - If sync2 == btn_stable: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: btn_stable <= sync2 and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any bounce back to the btn_stable value clears dcnt.
- Latency: let E0 be the first edge that samples btn_in=1. btn_stable rises at edge E0+1+DEBOUNCE_CYCLES (E0+5 at default). Falling is symmetric.
- FSM states: IDLE, HOLD, REPEAT. rcnt is the repeat counter.
  - IDLE: on the edge where btn_stable rises, t_pulse <= 1, rcnt <= 0, go to HOLD. The first pulse is high in the same cycle btn_stable first reads 1.
  - HOLD: rcnt increments each edge. When REPEAT_EN=1 and rcnt == REPEAT_DELAY-1, t_pulse <= 1, rcnt <= 0, go to REPEAT. When REPEAT_EN=0, stay in HOLD with no further pulses.
  - REPEAT: rcnt increments each edge. When rcnt == REPEAT_PERIOD-1, t_pulse <= 1 and rcnt <= 0.
  - Any state: on the edge where btn_stable falls, go to IDLE with t_pulse <= 0 and rcnt <= 0. Release takes priority over a pulse due on the same edge.
- t_pulse is 0 on every edge not listed above. It is never high for 2 consecutive cycles.
- pulse_count increments on every edge that sets t_pulse <= 1, wrapping 255 -> 0.
- Reset mid-operation: all state is cleared. If btn_in is still high after reset releases, the block treats it as a new press: full debounce latency, then a pulse, with pulse_count restarting from 0.
- Counter widths are sized with $clog2 of the parameters. No overflow is possible below the terminal values.

Test Plan:
1. reset=0 for 20 ns with btn_in=1 and clk toggling -> t_pulse, btn_stable and pulse_count stay 0. Release reset -> btn_stable and t_pulse rise 5 edges after the first sampling edge.
2. Clean press, btn_in=1 for 10 cycles then 0 (REPEAT_EN=1) -> exactly one t_pulse at E0+5. pulse_count=1. btn_stable falls 5 edges after the first edge sampling 0. No pulse on release.
3. Bounce: btn_in pattern 1,1,0,1,1,0,1 (1 cycle each) then 0 -> btn_stable never rises, t_pulse never asserts, pulse_count=0.
4. Hold for 40 cycles from E0 (default params):
   - Pulses at edges E0+5, +21, +29 and +37.
   - btn_stable falls at E0+45, coinciding with the due repeat pulse; no pulse at +45.
   - pulse_count=4.
   - Repeat with REPEAT_EN=0 -> only the +5 pulse, pulse_count=1.
5. 256 clean presses -> pulse_count returns to 0 after the 256th press.
6. Reset pulse at E0+25 during HOLD/REPEAT with btn_in held high -> outputs 0 immediately. After release, first pulse arrives 1+DEBOUNCE_CYCLES edges after the first post-reset edge, and pulse_count=1.
